rsfq_pulse_tx: RTL and testbench

Synthesizable SFQ stimulus transmitter that drives pulse-level inputs and clock pulses into the behavioural RSFQ gates (and_gate and siblings) during gate-level regression. It accepts N_CH-bit words over a valid/ready handshake and emits one clock-period frame per word. Data pulses are placed so the gate's hold/setup checks are always satisfied, and the gate is clocked to evaluate each word one frame later.

---
 rtl/rsfq_pulse_tx_pkg.sv | 17 +
 rtl/rsfq_pulse_tx_if.sv | 11 +
 rtl/rsfq_pulse_tx_timer.sv | 43 ++++
 rtl/rsfq_pulse_tx.sv | 137 +++++++++++++
 tb/tb_rsfq_pulse_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsfq_pulse_tx_pkg.sv
// Shared types and helpers for the SFQ stimulus transmitter.
package rsfq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } tx_state_e;

  localparam int FRAME_CNT_W = 16;

  // Cycle offset of the data pulse from the frame's clock pulse.
  function automatic int data_ofs(input int t_hold, input int t_setup);
    return t_hold + t_setup;
  endfunction

endpackage

// File: rtl/rsfq_pulse_tx_if.sv
// Word handshake between a stimulus source and rsfq_pulse_tx.
interface rsfq_pulse_tx_if #(
  parameter int N_CH = 2
);
  logic            s_valid;
  logic            s_ready;
  logic [N_CH-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/rsfq_pulse_tx_timer.sv
// Frame tick counter with wrap, last-tick flags and two pulse-window decodes.
module rsfq_frame_timer #(
  parameter int T_PERIOD   = 32,
  parameter int WIN0_START = 0,
  parameter int WIN1_START = 13,
  parameter int WIN_W      = 2,
  parameter int TW         = $clog2(T_PERIOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cnt_en_i,
  output logic [TW-1:0] t_o,
  output logic          last_o,
  output logic          last_nxt_o,
  output logic          win0_nxt_o,
  output logic          win1_nxt_o
);

  logic [TW-1:0] t_q, t_d;

  function automatic logic in_win(input logic [TW-1:0] t, input int start, input int width);
    return (int'(t) >= start) && (int'(t) < start + width);
  endfunction

  assign last_o = (t_q == TW'(T_PERIOD - 1));

  always_comb begin
    t_d = '0;
    if (cnt_en_i && !last_o) t_d = t_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) t_q <= '0;
    else     t_q <= t_d;
  end

  // Flags are decoded on the next tick so the top can register its outputs.
  assign t_o        = t_q;
  assign last_nxt_o = (t_d == TW'(T_PERIOD - 1));
  assign win0_nxt_o = in_win(t_d, WIN0_START, WIN_W);
  assign win1_nxt_o = in_win(t_d, WIN1_START, WIN_W);

endmodule

// File: rtl/rsfq_pulse_tx.sv
// SFQ stimulus transmitter: one clock-period frame per accepted word.
// Optional macro RSFQ_TX_EXPECT_EN adds exp_valid/exp_and reference outputs.
module rsfq_pulse_tx
  import rsfq_tx_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int T_PERIOD = 32,
  parameter int T_HOLD   = 12,
  parameter int T_SETUP  = 1,
  parameter int PULSE_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  rsfq_pulse_tx_if.slave         s,
  output logic [N_CH-1:0]        pulse_out,
  output logic                   clk_out,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef RSFQ_TX_EXPECT_EN
  ,
  output logic                   exp_valid,
  output logic                   exp_and
`endif
);

  localparam int DATA_OFS = data_ofs(T_HOLD, T_SETUP);
  localparam int TW       = $clog2(T_PERIOD);

  if (T_PERIOD < DATA_OFS + PULSE_W + T_SETUP + 1 || PULSE_W < 1) begin : g_bad_cfg
    $error("rsfq_pulse_tx: T_PERIOD too short for hold/setup/pulse width");
  end

  tx_state_e              state_q, state_d;
  logic                   first_q, first_d;
  logic [N_CH-1:0]        word_q, word_d;
  logic                   ready_q, ready_d;
  logic                   clk_q, clk_d;
  logic [N_CH-1:0]        pulse_q, pulse_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   accept, cnt_en, clk_rise;
  logic [TW-1:0]          t_cur;
  logic                   last, last_nxt, clk_win, data_win;

  rsfq_frame_timer #(
    .T_PERIOD  (T_PERIOD),
    .WIN0_START(0),
    .WIN1_START(DATA_OFS),
    .WIN_W     (PULSE_W),
    .TW        (TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .cnt_en_i  (cnt_en),
    .t_o       (t_cur),
    .last_o    (last),
    .last_nxt_o(last_nxt),
    .win0_nxt_o(clk_win),
    .win1_nxt_o(data_win)
  );

  assign accept = s.s_valid && ready_q;

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        first_d = 1'b1;
        word_d  = s.s_data;
      end
      RUN: if (last) begin
        first_d = 1'b0;
        if (accept) word_d  = s.s_data;
        else        state_d = TAIL;
      end
      TAIL: if (t_cur == TW'(PULSE_W - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter restarts from 0 whenever a frame sequence begins or ends.
  assign cnt_en   = (state_q != IDLE) && (state_d != IDLE);
  assign clk_d    = (((state_d == RUN) && !first_d) || (state_d == TAIL)) && clk_win;
  assign pulse_d  = ((state_d == RUN) && data_win) ? word_d : '0;
  assign ready_d  = (state_d == IDLE) || ((state_d == RUN) && last_nxt);
  assign clk_rise = clk_d && !clk_q;
  assign cnt_d    = cnt_q + FRAME_CNT_W'(clk_rise);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      ready_q <= 1'b0;
      clk_q   <= 1'b0;
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      ready_q <= ready_d;
      clk_q   <= clk_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign s.s_ready = ready_q;
  assign pulse_out = pulse_q;
  assign clk_out   = clk_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = cnt_q;

`ifdef RSFQ_TX_EXPECT_EN
  // word_q still holds the previous frame's word when its evaluating clock rises.
  logic ev_q, ea_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_q <= 1'b0;
      ea_q <= 1'b0;
    end else begin
      ev_q <= clk_rise;
      ea_q <= clk_rise && (&word_q);
    end
  end

  assign exp_valid = ev_q;
  assign exp_and   = ea_q;
`endif

endmodule

// File: tb/tb_rsfq_pulse_tx.sv
// Scoreboard bench for rsfq_pulse_tx; honours RSFQ_TX_EXPECT_EN when defined.
module tb_rsfq_pulse_tx;
  import rsfq_tx_pkg::*;

  localparam int N_CH     = 2;
  localparam int T_PERIOD = 32;
  localparam int T_HOLD   = 12;
  localparam int T_SETUP  = 1;
  localparam int PULSE_W  = 2;
  localparam int DATA_OFS = T_HOLD + T_SETUP;
`ifdef RSFQ_TX_EXPECT_EN
  localparam int OW = N_CH + 3 + FRAME_CNT_W + 2;
`else
  localparam int OW = N_CH + 3 + FRAME_CNT_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rsfq_pulse_tx_if #(.N_CH(N_CH)) s_if ();

  logic [N_CH-1:0]        pulse_out;
  logic                   clk_out, busy;
  logic [FRAME_CNT_W-1:0] frame_cnt;
`ifdef RSFQ_TX_EXPECT_EN
  logic                   exp_valid, exp_and;
`endif

  rsfq_pulse_tx #(
    .N_CH(N_CH), .T_PERIOD(T_PERIOD), .T_HOLD(T_HOLD), .T_SETUP(T_SETUP), .PULSE_W(PULSE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (s_if.slave),
    .pulse_out(pulse_out),
    .clk_out  (clk_out),
    .busy     (busy),
    .frame_cnt(frame_cnt)
`ifdef RSFQ_TX_EXPECT_EN
    ,
    .exp_valid(exp_valid),
    .exp_and  (exp_and)
`endif
  );

  logic [OW-1:0] obs;
`ifdef RSFQ_TX_EXPECT_EN
  assign obs = {pulse_out, clk_out, busy, s_if.s_ready, frame_cnt, exp_valid, exp_and};
`else
  assign obs = {pulse_out, clk_out, busy, s_if.s_ready, frame_cnt};
`endif

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] p;
    logic            k;
    logic            rise;
    logic            ea;
  } ev_t;

  ev_t              q[$];
  int               cyc = 0;
  int               busy_end = -1;
  int               rdy_at = -1;
  int               acc_cyc = -1;
  int               n_acc = 0;
  logic             acc_flag = 1'b0;
  logic             rst_edge = 1'b1;
  logic [FRAME_CNT_W-1:0] exp_cnt = '0;
  logic [OW-1:0]    want;
  int               total = 0;
  int               bad = 0;

  // Advance one cycle: book any handshake into the scoreboard, then pop expectations.
  task automatic tick();
    logic [N_CH-1:0] ep;
    logic ek, eev, eea, ebusy, erdy;
    acc_flag = 1'b0;
    if (rst) begin
      q.delete();
      busy_end = -1;
      rdy_at   = -1;
      exp_cnt  = '0;
    end else if (s_if.s_valid && s_if.s_ready) begin
      acc_flag = 1'b1;
      acc_cyc  = cyc;
      n_acc++;
      for (int i = 0; i < PULSE_W; i++) begin
        q.push_back('{cyc + 1 + DATA_OFS + i, s_if.s_data, 1'b0, 1'b0, 1'b0});
        q.push_back('{cyc + 1 + T_PERIOD + i, {N_CH{1'b0}}, 1'b1, (i == 0), (i == 0) && (&s_if.s_data)});
      end
      busy_end = cyc + T_PERIOD + PULSE_W;
      rdy_at   = cyc + T_PERIOD;
    end
    rst_edge = rst;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    ep = '0; ek = 1'b0; eev = 1'b0; eea = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        ep  = ep | q[i].p;
        ek  = ek | q[i].k;
        eea = eea | q[i].ea;
        if (q[i].rise) begin
          eev = 1'b1;
          exp_cnt = exp_cnt + 1'b1;
        end
        q.delete(i);
      end
    end
    ebusy = (cyc <= busy_end);
    erdy  = !rst_edge && ((cyc > busy_end) || (cyc == rdy_at));
`ifdef RSFQ_TX_EXPECT_EN
    want = {ep, ek, ebusy, erdy, exp_cnt, eev, eea};
`else
    want = {ep, ek, ebusy, erdy, exp_cnt};
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 2'b11;
    repeat (3) begin
      tick();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, obs, want);
      end
    end
    rst = 1'b0;
    s_if.s_valid = 1'b0;
    tick();
    total++;
    if ({s_if.s_ready, busy, clk_out, pulse_out, frame_cnt} !== {1'b1, 1'b0, 1'b0, {N_CH{1'b0}}, 16'h0}) begin
      bad++;
      $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, obs, want);
    end
  endtask

  task automatic test_single();
    int acc0;
    acc0 = n_acc;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 2'b11;
    repeat (T_PERIOD + PULSE_W + 6) begin
      tick();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs, want);
      end
      if (acc_flag) begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = 2'b00;
      end
    end
    total++;
    if (n_acc - acc0 !== 1) begin
      bad++;
      $display("FAIL single_accepts got=%0d want=1", n_acc - acc0);
    end
  endtask

  task automatic test_stream();
    logic [N_CH-1:0] w [3];
    int acc [3];
    int k;
    w[0] = 2'b01; w[1] = 2'b10; w[2] = 2'b11;
    k = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = w[0];
    repeat (3 * T_PERIOD + 16) begin
      tick();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL stream cyc=%0d got=%h want=%h", cyc, obs, want);
      end
      if (acc_flag && k < 3) begin
        acc[k] = acc_cyc;
        k++;
        if (k == 3) s_if.s_valid = 1'b0;
        else        s_if.s_data  = w[k];
      end
    end
    s_if.s_valid = 1'b0;
    total++;
    if (k !== 3 || acc[1] - acc[0] !== T_PERIOD || acc[2] - acc[1] !== T_PERIOD) begin
      bad++;
      $display("FAIL stream_spacing got=%0d words gaps %0d %0d want=3 words gaps %0d", k,
               (k > 1) ? acc[1] - acc[0] : -1, (k > 2) ? acc[2] - acc[1] : -1, T_PERIOD);
    end
  endtask

  task automatic test_backpressure();
    int first;
    int got;
    got = -1;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 2'b01;
    tick();
    first = acc_cyc;
    s_if.s_valid = 1'b0;
    repeat (5) tick();
    s_if.s_valid = 1'b1;
    s_if.s_data  = 2'b10;
    for (int i = 0; i < T_PERIOD + 4; i++) begin
      tick();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL backpressure cyc=%0d got=%h want=%h", cyc, obs, want);
      end
      if (acc_flag && got < 0) begin
        got = acc_cyc;
        s_if.s_valid = 1'b0;
        s_if.s_data  = 2'b11;
      end
    end
    s_if.s_valid = 1'b0;
    total++;
    if (got !== first + T_PERIOD) begin
      bad++;
      $display("FAIL backpressure_accept got=%0d want=%0d", got, first + T_PERIOD);
    end
    repeat (T_PERIOD + 4) begin
      tick();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL backpressure_drain cyc=%0d got=%h want=%h", cyc, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    int target;
    int n;
    target = -1;
    n = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 2'b11;
    while (cyc != target && n < 3 * T_PERIOD) begin
      tick();
      n++;
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_mid_run cyc=%0d got=%h want=%h", cyc, obs, want);
      end
      if (acc_flag) begin
        if (s_if.s_data == 2'b11) s_if.s_data = 2'b10;
        else begin
          s_if.s_valid = 1'b0;
          target = acc_cyc + 1 + DATA_OFS;
        end
      end
    end
    total++;
    if (cyc !== target || pulse_out !== 2'b10) begin
      bad++;
      $display("FAIL reset_mid_reach cyc=%0d pulse=%b want cyc=%0d pulse=10", cyc, pulse_out, target);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({pulse_out, clk_out, busy, s_if.s_ready, frame_cnt} !== {{N_CH{1'b0}}, 3'b000, 16'h0}) begin
      bad++;
      $display("FAIL reset_mid_clear cyc=%0d got=%h want=0", cyc, obs);
    end
    repeat (T_PERIOD + 8) begin
      tick();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_mid_after cyc=%0d got=%h want=%h", cyc, obs, want);
      end
    end
  endtask

`ifdef RSFQ_TX_EXPECT_EN
  task automatic test_expect_wrap();
    int nev;
    nev = 0;
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 2'b11;
    repeat (2 * T_PERIOD + 12) begin
      tick();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL expect_wrap cyc=%0d got=%h want=%h", cyc, obs, want);
      end
      if (exp_valid) nev++;
      if (acc_flag) begin
        if (s_if.s_data == 2'b11) s_if.s_data = 2'b10;
        else s_if.s_valid = 1'b0;
      end
    end
    s_if.s_valid = 1'b0;
    total++;
    if (nev !== 2 || frame_cnt !== 16'h0001) begin
      bad++;
      $display("FAIL expect_count got=%0d cnt=%h want=2 cnt=0001", nev, frame_cnt);
    end
  endtask
`endif

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_reset_mid();
`ifdef RSFQ_TX_EXPECT_EN
    test_expect_wrap();
`endif
    total++;
    if (q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
